// File: rtl/scr_base_l3_bk_tp_d0_arb.sv
// L3 bank tag pipe D0: arbitrates request sources, blocks same-set hazards against
// the in-flight tracker, allocates a tracker id and loads the registered D1 stage.
module scr_base_l3_bk_tp_d0_arb #(
  parameter int N_SRC       = 4,
  parameter int ADDR_W      = 40,
  parameter int LINE_OFFS_W = 6,
  parameter int SET_W       = 10,
  parameter int OP_W        = 4,
  parameter int TRK_DEPTH   = 8,
  parameter int HI_PRIO_EN  = 1,
  localparam int SRC_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int TID_W      = (TRK_DEPTH > 1) ? $clog2(TRK_DEPTH) : 1,
  localparam int CNT_W      = TID_W + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        req_vld_i,
  output logic [N_SRC-1:0]        req_rdy_o,
  input  logic [N_SRC*ADDR_W-1:0] req_addr_i,
  input  logic [N_SRC*OP_W-1:0]   req_op_i,
  output logic                    d1_vld_o,
  input  logic                    d1_rdy_i,
  output logic [SRC_W-1:0]        d1_src_o,
  output logic [ADDR_W-1:0]       d1_addr_o,
  output logic [SET_W-1:0]        d1_set_o,
  output logic [OP_W-1:0]         d1_op_o,
  output logic [TID_W-1:0]        d1_tid_o,
  input  logic                    rls_vld_i,
  input  logic [TID_W-1:0]        rls_tid_i,
  output logic [CNT_W-1:0]        trk_cnt_o,
  output logic                    trk_full_o
);

  logic [TRK_DEPTH-1:0] trk_vld;
  logic [SET_W-1:0]     trk_set [TRK_DEPTH];
  logic [SRC_W-1:0]     rr_ptr;

  logic [SET_W-1:0]     req_set_p0 [N_SRC];
  logic [N_SRC-1:0]     hit_p0;
  logic [N_SRC-1:0]     elig_p0;
  logic                 can_load_p0;
  logic                 hi_sel_p0;
  logic [SRC_W-1:0]     rr_idx_p0;
  logic                 gnt_vld_p0;
  logic [SRC_W-1:0]     gnt_idx_p0;
  logic [ADDR_W-1:0]    gnt_addr_p0;
  logic [OP_W-1:0]      gnt_op_p0;
  logic [SET_W-1:0]     gnt_set_p0;
  logic [TID_W-1:0]     free_tid_p0;
  logic                 rls_hit_p0;

  function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= N_SRC) s = s - N_SRC;
    return SRC_W'(s);
  endfunction

  assign trk_full_o  = (trk_cnt_o == CNT_W'(TRK_DEPTH));
  assign can_load_p0 = !d1_vld_o || d1_rdy_i;
  // A release only frees an entry that is actually held; stray releases are dropped.
  assign rls_hit_p0  = rls_vld_i && trk_vld[rls_tid_i];

  // ---- D0: hazard check against in-flight sets ----
  always_comb begin
    hit_p0  = '0;
    elig_p0 = '0;
    for (int k = 0; k < N_SRC; k++) begin
      req_set_p0[k] = req_addr_i[k*ADDR_W+LINE_OFFS_W +: SET_W];
      for (int e = 0; e < TRK_DEPTH; e++) begin
        if (trk_vld[e] && (trk_set[e] == req_set_p0[k])) hit_p0[k] = 1'b1;
      end
      elig_p0[k] = req_vld_i[k] && !hit_p0[k] && !trk_full_o;
    end
  end

  // Downward scan so the lowest offset from rr_ptr wins.
  always_comb begin
    hi_sel_p0 = (HI_PRIO_EN != 0) && elig_p0[0];
    rr_idx_p0 = '0;
    for (int i = N_SRC-1; i >= 0; i--) begin
      if (elig_p0[wrap_add(rr_ptr, i)]) rr_idx_p0 = wrap_add(rr_ptr, i);
    end
    gnt_vld_p0 = can_load_p0 && (|elig_p0);
    gnt_idx_p0 = hi_sel_p0 ? '0 : rr_idx_p0;
  end

  always_comb begin
    gnt_addr_p0 = '0;
    gnt_op_p0   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (gnt_idx_p0 == SRC_W'(k)) begin
        gnt_addr_p0 = req_addr_i[k*ADDR_W +: ADDR_W];
        gnt_op_p0   = req_op_i[k*OP_W +: OP_W];
      end
    end
    gnt_set_p0 = gnt_addr_p0[LINE_OFFS_W +: SET_W];
  end

  // Entries released this cycle are still marked valid, so they are never reused here.
  always_comb begin
    free_tid_p0 = '0;
    for (int e = TRK_DEPTH-1; e >= 0; e--) begin
      if (!trk_vld[e]) free_tid_p0 = TID_W'(e);
    end
  end

  always_comb begin
    req_rdy_o = '0;
    if (gnt_vld_p0 && rst_n) req_rdy_o[gnt_idx_p0] = 1'b1;
  end

  // ---- D0 -> D1 boundary: control state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_vld_o  <= 1'b0;
      rr_ptr    <= '0;
      trk_vld   <= '0;
      trk_cnt_o <= '0;
    end else begin
      if (gnt_vld_p0) d1_vld_o <= 1'b1;
      else if (d1_rdy_i) d1_vld_o <= 1'b0;
      if (gnt_vld_p0 && !hi_sel_p0) begin
        rr_ptr <= (gnt_idx_p0 == SRC_W'(N_SRC-1)) ? '0 : gnt_idx_p0 + SRC_W'(1);
      end
      if (rls_hit_p0) trk_vld[rls_tid_i] <= 1'b0;
      if (gnt_vld_p0) trk_vld[free_tid_p0] <= 1'b1;
      if (gnt_vld_p0 && !rls_hit_p0) trk_cnt_o <= trk_cnt_o + CNT_W'(1);
      else if (!gnt_vld_p0 && rls_hit_p0) trk_cnt_o <= trk_cnt_o - CNT_W'(1);
    end
  end

  // ---- D0 -> D1 boundary: payload and tracker sets ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_src_o  <= '0;
      d1_addr_o <= '0;
      d1_set_o  <= '0;
      d1_op_o   <= '0;
      d1_tid_o  <= '0;
      for (int e = 0; e < TRK_DEPTH; e++) trk_set[e] <= '0;
    end else if (gnt_vld_p0) begin
      d1_src_o             <= gnt_idx_p0;
      d1_addr_o            <= gnt_addr_p0;
      d1_set_o             <= gnt_set_p0;
      d1_op_o              <= gnt_op_p0;
      d1_tid_o             <= free_tid_p0;
      trk_set[free_tid_p0] <= gnt_set_p0;
    end
  end

  rls_valid_entry_a: assert property (@(posedge clk) disable iff (!rst_n)
    rls_vld_i |-> trk_vld[rls_tid_i]);

endmodule

// File: tb/tb_scr_base_l3_bk_tp_d0_arb.sv
// Scoreboard bench for the L3 tag pipe D0 arbiter: a queue-based reference model
// predicts grants and D1 payloads; a negedge monitor compares accepted D1 transfers.
module tb_scr_base_l3_bk_tp_d0_arb;
  localparam int N    = 4;
  localparam int AW   = 40;
  localparam int LO   = 6;
  localparam int SW   = 10;
  localparam int OW   = 4;
  localparam int TD   = 8;
  localparam int HP   = 1;
  localparam int SRCW = 2;
  localparam int TIDW = 3;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_vld, req_rdy;
  logic [N*AW-1:0] req_addr;
  logic [N*OW-1:0] req_op;
  logic            d1_vld, d1_rdy;
  logic [SRCW-1:0] d1_src;
  logic [AW-1:0]   d1_addr;
  logic [SW-1:0]   d1_set;
  logic [OW-1:0]   d1_op;
  logic [TIDW-1:0] d1_tid;
  logic            rls_vld;
  logic [TIDW-1:0] rls_tid;
  logic [CW-1:0]   trk_cnt;
  logic            trk_full;

  scr_base_l3_bk_tp_d0_arb #(
    .N_SRC(N), .ADDR_W(AW), .LINE_OFFS_W(LO), .SET_W(SW), .OP_W(OW),
    .TRK_DEPTH(TD), .HI_PRIO_EN(HP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld_i(req_vld), .req_rdy_o(req_rdy), .req_addr_i(req_addr), .req_op_i(req_op),
    .d1_vld_o(d1_vld), .d1_rdy_i(d1_rdy), .d1_src_o(d1_src), .d1_addr_o(d1_addr),
    .d1_set_o(d1_set), .d1_op_o(d1_op), .d1_tid_o(d1_tid),
    .rls_vld_i(rls_vld), .rls_tid_i(rls_tid), .trk_cnt_o(trk_cnt), .trk_full_o(trk_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SRCW-1:0] src;
    logic [AW-1:0]   addr;
    logic [SW-1:0]   set;
    logic [OW-1:0]   op;
    logic [TIDW-1:0] tid;
  } txn_t;

  txn_t exp_q[$];
  txn_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   uniq   = 64;

  // Reference model: occupancy map of tracker ids, set per id, rr pointer, D1 occupancy.
  bit            m_busy [TD];
  logic [SW-1:0] m_set  [TD];
  int            m_cnt, m_rr;
  bit            m_vld;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < TD; e++) begin
      m_busy[e] = 1'b0;
      m_set[e]  = '0;
    end
    m_cnt = 0;
    m_rr  = 0;
    m_vld = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit            el [N];
    bit            hit;
    int            g, tid;
    logic [SW-1:0] s;
    txn_t          t;
    bit            rel;
    g   = -1;
    tid = -1;
    for (int k = 0; k < N; k++) begin
      s   = req_addr[k*AW+LO +: SW];
      hit = 1'b0;
      for (int e = 0; e < TD; e++) if (m_busy[e] && m_set[e] == s) hit = 1'b1;
      el[k] = req_vld[k] && !hit && (m_cnt < TD);
    end
    if (!m_vld || d1_rdy) begin
      if (HP != 0 && el[0]) g = 0;
      else for (int i = 0; i < N; i++) if (g < 0 && el[(m_rr + i) % N]) g = (m_rr + i) % N;
    end
    chk("req_rdy", 64'(req_rdy), (g >= 0) ? 64'(1) << g : 64'(0));
    chk("trk_cnt", 64'(trk_cnt), 64'(m_cnt));
    chk("trk_full", 64'(trk_full), 64'(m_cnt == TD));
    chk("d1_vld", 64'(d1_vld), 64'(m_vld));
    rel = rls_vld && m_busy[rls_tid];
    if (g >= 0) begin
      for (int e = TD-1; e >= 0; e--) if (!m_busy[e]) tid = e;
      t.src  = SRCW'(g);
      t.addr = req_addr[g*AW +: AW];
      t.set  = t.addr[LO +: SW];
      t.op   = req_op[g*OW +: OW];
      t.tid  = TIDW'(tid);
      exp_q.push_back(t);
      if (!(HP != 0 && el[0])) m_rr = (g + 1) % N;
      m_busy[tid] = 1'b1;
      m_set[tid]  = t.set;
      m_cnt++;
      m_vld = 1'b1;
    end else if (d1_rdy) begin
      m_vld = 1'b0;
    end
    if (rel) begin
      m_busy[rls_tid] = 1'b0;
      m_cnt--;
    end
  endtask

  // Inputs are driven 1 ns after posedge; everything is checked at the following negedge.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_req_rdy", 64'(req_rdy), 64'(0));
      chk("rst_d1_vld", 64'(d1_vld), 64'(0));
      chk("rst_trk_cnt", 64'(trk_cnt), 64'(0));
      chk("rst_d1_data", 64'({d1_src, d1_set, d1_op, d1_tid}) | 64'(d1_addr), 64'(0));
    end else begin
      model_step();
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && d1_vld === 1'b1 && d1_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("d1_unexpected", 64'(1), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("d1_txn", 64'({d1_src, d1_addr, d1_set, d1_op, d1_tid}), 64'(mon_e));
      end
    end
  end

  task automatic set_req(input int k, input logic v, input logic [SW-1:0] s);
    logic [AW-1:0] a;
    a = AW'({$urandom, $urandom});
    a[LO +: SW] = s;
    req_vld[k] = v;
    req_addr[k*AW +: AW] = a;
    req_op[k*OW +: OW] = OW'($urandom);
  endtask

  function automatic logic [SW-1:0] fresh();
    uniq = (uniq + 1) % 1024;
    if (uniq < 64) uniq = 64;
    return SW'(uniq);
  endfunction

  task automatic pick_rls(input int pct);
    int cand[$];
    rls_vld = 1'b0;
    rls_tid = '0;
    for (int e = 0; e < TD; e++) if (m_busy[e]) cand.push_back(e);
    if (cand.size() > 0 && int'($urandom_range(0, 99)) < pct) begin
      rls_vld = 1'b1;
      rls_tid = TIDW'(cand[$urandom_range(0, cand.size() - 1)]);
    end
  endtask

  task automatic drain();
    req_vld = '0;
    d1_rdy  = 1'b1;
    repeat (TD + 3) begin
      pick_rls(100);
      tick();
    end
    rls_vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_vld = '0; req_addr = '0; req_op = '0;
    d1_rdy = 1'b1; rls_vld = 1'b0; rls_tid = '0;
    model_reset();
    // reset with every source requesting
    for (int k = 0; k < N; k++) set_req(k, 1'b1, SW'(16 + k));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    req_vld = '0;
    tick();
    chk("first_tid_zero", 64'(d1_tid), 64'(0));
    drain();
    // round robin among sources 1..3 (src 0 idle)
    for (int c = 0; c < 5; c++) begin
      set_req(0, 1'b0, fresh());
      for (int k = 1; k < N; k++) set_req(k, 1'b1, fresh());
      tick();
    end
    drain();
    // two sources on the same set
    set_req(1, 1'b1, SW'(5));
    set_req(2, 1'b1, SW'(5));
    tick();
    req_vld[1] = 1'b0;
    repeat (3) tick();
    repeat (TD) begin
      pick_rls(100);
      tick();
    end
    rls_vld = 1'b0;
    repeat (3) tick();
    drain();
    // D1 back-pressure
    set_req(1, 1'b1, fresh());
    tick();
    d1_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < N; k++) set_req(k, 1'b1, fresh());
      tick();
    end
    d1_rdy = 1'b1;
    tick();
    drain();
    // fill the tracker, then free tid 3 with requests waiting
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < N; k++) set_req(k, 1'b1, fresh());
      tick();
    end
    chk("full_after_fill", 64'(trk_full), 64'(1));
    rls_vld = 1'b1;
    rls_tid = TIDW'(3);
    tick();
    rls_vld = 1'b0;
    repeat (3) tick();
    drain();
    // randomized traffic over a small set pool, with one mid-run reset
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rst_n = 1'b0;
        model_reset();
        rls_vld = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      for (int k = 0; k < N; k++)
        set_req(k, logic'($urandom_range(0, 1)), SW'($urandom_range(0, 11)));
      d1_rdy = ($urandom_range(0, 99) < 70);
      pick_rls(35);
      tick();
    end
    drain();
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
